// File: rtl/sync_fifo_pkg.sv
// Shared defaults and width helpers for the programmable-threshold synchronous FIFO.
package sync_fifo_pkg;

    localparam int unsigned DEF_FIFO_DEPTH = 8;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_AE_LEVEL   = 2;

    // Pointer width for a power-of-two depth.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the count can represent a completely full FIFO.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned WIDTH = DEF_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        wr_en_i,
    input  logic [ptr_width(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]            wr_data_i,
    input  logic [ptr_width(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]            rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/empty levels and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data.
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int unsigned AE_LEVEL   = DEF_AE_LEVEL
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cs,
    input  logic                             wr_en,
    input  logic                             rd_en,
    input  logic                             err_clr,
    input  logic [DATA_WIDTH-1:0]            data_in,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             empty,
    output logic                             full,
    output logic                             almost_full,
    output logic                             almost_empty,
    output logic [cnt_width(FIFO_DEPTH)-1:0] count,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int unsigned PTR_W = ptr_width(FIFO_DEPTH);
    localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_data;

    sync_fifo_mem #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (data_in),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

    // Next-state for pointers, occupancy, level flags and sticky errors.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        wr_acc = cs & wr_en & ~full_q;
        rd_acc = cs & rd_en & ~empty_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_W'(1);
        end

        // Clear first so a same-cycle set wins.
        if (cs && err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (cs && wr_en && full_q) begin
            ovf_d = 1'b1;
        end
        if (cs && rd_en && empty_q) begin
            unf_d = 1'b1;
        end

        empty_d  = (count_d == CNT_W'(0));
        full_d   = (count_d == CNT_W'(FIFO_DEPTH));
        afull_d  = (count_d >= CNT_W'(AF_LEVEL));
        aempty_d = (count_d <= CNT_W'(AE_LEVEL));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is shown as soon as it exists; zero while nothing is stored.
    assign data_out = empty_q ? '0 : rd_data;
`else
    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (rd_acc) begin
            data_d = rd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;
`endif

    assign count        = count_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: directed boundary sequences plus random traffic vs a queue model.
module tb_sync_fifo_prog;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned AF    = 6;
    localparam int unsigned AE    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs, wr_en, rd_en, err_clr;
    logic [DW-1:0] data_in, data_out;
    logic          empty, full, almost_full, almost_empty;
    logic [3:0]    count;
    logic          overflow, underflow;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the stored words in order, sticky flags and last popped word.
    logic [DW-1:0] mq [$];
    logic          m_ovf, m_unf;
    logic [DW-1:0] m_dout;

    sync_fifo_prog #(
        .FIFO_DEPTH (DEPTH),
        .DATA_WIDTH (DW),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cs           (cs),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .err_clr      (err_clr),
        .data_in      (data_in),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        logic [DW-1:0] exp_dout;
        n = mq.size();
`ifdef SYNC_FIFO_FWFT_EN
        exp_dout = (n > 0) ? mq[0] : '0;
`else
        exp_dout = m_dout;
`endif
        check_eq({tag, ".count"}, 64'(count), 64'(n));
        check_eq({tag, ".empty"}, 64'(empty), 64'(n == 0));
        check_eq({tag, ".full"},  64'(full),  64'(n == int'(DEPTH)));
        check_eq({tag, ".afull"}, 64'(almost_full),  64'(n >= int'(AF)));
        check_eq({tag, ".aempty"}, 64'(almost_empty), 64'(n <= int'(AE)));
        check_eq({tag, ".ovf"},   64'(overflow),  64'(m_ovf));
        check_eq({tag, ".unf"},   64'(underflow), 64'(m_unf));
        check_eq({tag, ".dout"},  64'(data_out),  64'(exp_dout));
    endtask

    // One clock of stimulus; the model advances with the same rules, then all outputs are checked.
    task automatic step(input string tag, input logic c, input logic w, input logic r,
                        input logic e, input logic [DW-1:0] d);
        bit was_full, was_empty;
        @(negedge clk);
        cs = c; wr_en = w; rd_en = r; err_clr = e; data_in = d;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        m_ovf = (c && w && was_full)  || (m_ovf && !(c && e));
        m_unf = (c && r && was_empty) || (m_unf && !(c && e));
        if (c && r && !was_empty) m_dout = mq.pop_front();
        if (c && w && !was_full)  mq.push_back(d);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dout = '0;
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; data_in = '0;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Three writes then three reads, order preserved.
        step("w1",   1, 1, 0, 0, 32'd1);
        step("w10",  1, 1, 0, 0, 32'd10);
        step("w100", 1, 1, 0, 0, 32'd100);
        repeat (3) step("r3", 1, 0, 1, 0, '0);

        // Fill to full with powers of two, overflow on the ninth, drain.
        for (int i = 0; i < 8; i++) step("fill", 1, 1, 0, 0, DW'(1) << i);
        step("wovf", 1, 1, 0, 0, 32'hDEAD_BEEF);
        for (int i = 0; i < 8; i++) step("drain", 1, 0, 1, 0, '0);
        step("clr", 1, 0, 0, 1, '0);

        // Alternate write/read to wrap both pointers twice.
        for (int i = 0; i < 16; i++) begin
            step("altw", 1, 1, 0, 0, DW'($urandom));
            step("altr", 1, 0, 1, 0, '0);
        end

        // Simultaneous read/write at full and at empty.
        for (int i = 0; i < 8; i++) step("fill2", 1, 1, 0, 0, DW'(i + 32'h100));
        step("rw_full", 1, 1, 1, 0, 32'h5555);
        repeat (7) step("drain2", 1, 0, 1, 0, '0);
        step("rw_empty", 1, 1, 1, 0, 32'h7777);
        step("rd_last", 1, 0, 1, 0, '0);
        step("clr2", 1, 0, 0, 1, '0);

        // Underflow stickiness, clear racing a new underflow, cs gating.
        step("unf",      1, 0, 1, 0, '0);
        step("unf_hold", 1, 0, 0, 0, '0);
        step("clr_nocs", 0, 0, 0, 1, '0);
        step("clr_race", 1, 0, 1, 1, '0);
        step("clr3",     1, 0, 0, 1, '0);
        step("w_nocs",   0, 1, 1, 0, 32'h1234);

        // Asynchronous reset mid-fill at count 5.
        for (int i = 0; i < 5; i++) step("pre_rst", 1, 1, 0, 0, DW'(32'hC0 + i));
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0; cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        step("post_rst", 1, 0, 0, 0, '0);

        step("wA5", 1, 1, 0, 0, 32'hA5);
`ifdef SYNC_FIFO_FWFT_EN
        check_eq("fwft_a5", 64'(data_out), 64'h0000_00A5);
`endif
        step("rA5", 1, 0, 1, 0, '0);

        // Random traffic in phases biased toward filling, draining and balance.
        for (int ph = 0; ph < 6; ph++) begin
            int pw;
            int pr;
            pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
            pr = 100 - pw;
            for (int k = 0; k < 80; k++) begin
                step("rand",
                     logic'($urandom_range(9) != 0),
                     logic'($urandom_range(99) < pw),
                     logic'($urandom_range(99) < pr),
                     logic'($urandom_range(15) == 0),
                     DW'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_prog.md
SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, entry count (power of 2, >=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bits per entry.
REQ-003 SHALL have parameter AF_LEVEL, default FIFO_DEPTH-2, almost_full threshold (1..FIFO_DEPTH).
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold (0..FIFO_DEPTH-1).
REQ-005 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port cs  in  1  chip select; wr_en, rd_en and err_clr are ignored while low.
REQ-008 SHALL have port wr_en  in  1  write request.
REQ-009 SHALL have port rd_en  in  1  read request.
REQ-010 SHALL have port err_clr  in  1  clears the sticky error flags.
REQ-011 SHALL have port data_in  in  DATA_WIDTH  write data.
REQ-012 SHALL have port data_out  out  DATA_WIDTH  read data.
REQ-013 SHALL have ports empty, full, almost_full and almost_empty  out  1  each, level flags.
REQ-014 SHALL have port count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-015 SHALL have ports overflow and underflow  out  1  each, sticky error flags.

Function
REQ-016 A write SHALL be accepted iff cs & wr_en & !full; data_in is stored at wr_ptr and wr_ptr increments.
REQ-017 A read SHALL be accepted iff cs & rd_en & !empty; rd_ptr increments.
REQ-018 Accepted read and write in the same cycle SHALL both complete, leaving count unchanged, including at full (read only, write rejected) and at empty (write only, read rejected).
REQ-019 Pointers SHALL be $clog2(FIFO_DEPTH) bits wide and wrap from FIFO_DEPTH-1 to 0 with no gap.
REQ-020 count SHALL increment on a write-only accept, decrement on a read-only accept, and hold otherwise.
REQ-021 empty SHALL equal (count==0), full SHALL equal (count==FIFO_DEPTH), almost_full SHALL equal (count>=AF_LEVEL), and almost_empty SHALL equal (count<=AE_LEVEL); all are derived from the registered count and are valid in the same cycle as count.
REQ-022 overflow SHALL set on cs & wr_en & full, and underflow SHALL set on cs & rd_en & empty.
REQ-023 Both error flags SHALL hold until cs & err_clr; set takes priority over clear in the same cycle.
REQ-024 Rejected operations SHALL NOT change pointers, count or memory.
REQ-025 In default mode, data_out SHALL register mem[rd_ptr] on the edge of an accepted read (1-cycle latency) and hold its value otherwise.

Reset
REQ-026 rst high SHALL immediately clear wr_ptr, rd_ptr, count, overflow, underflow and data_out to 0, independent of clk.
REQ-027 During reset, outputs SHALL be empty=1, almost_empty=1, full=0, almost_full=0.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries.

Configuration
REQ-030 Macro SYNC_FIFO_FWFT_EN, when defined, SHALL select first-word-fall-through mode: data_out = mem[rd_ptr] combinationally while !empty, data_out = 0 while empty, and a read pops the shown word.
REQ-031 In FWFT mode, a word written into an empty FIFO SHALL appear on data_out in the cycle after the write edge.
REQ-032 When SYNC_FIFO_FWFT_EN is undefined, REQ-025 SHALL apply.
REQ-033 Flags and count SHALL be identical in both modes.

Structure
REQ-034 Shared package sync_fifo_pkg SHALL hold the default parameter values and the pointer/count width helper constants.
REQ-035 The storage array SHALL be a sub-module sync_fifo_mem: FIFO_DEPTH x DATA_WIDTH, one synchronous write port and one asynchronous read port.
REQ-036 Control, flag and error logic SHALL live in sync_fifo_prog.

Verification
REQ-037 Reset, then write 1, 10, 100, then 3 reads -> data_out 1, 10, 100 in order; count 0,1,2,3,2,1,0; empty=1 at end.
REQ-038 Write 2**i for i=0..7 -> full=1, count=8; almost_full=1 from count=6; a 9th write sets overflow with no data change; 8 reads return 1..128 in order.
REQ-039 Alternate write/read 16 times -> pointers wrap twice; each read returns the last value written; count stays within 0..1.
REQ-040 At count=8, assert wr_en & rd_en together -> read accepted, write rejected, count=7, overflow set; at count=0, both together -> count=1, underflow set.
REQ-041 Read while empty -> underflow=1 until err_clr; err_clr together with a new underflow -> flag stays 1.
REQ-042 Assert rst asynchronously mid-fill at count=5 -> count=0 and empty=1 before the next clk edge; with FWFT enabled, write 0xA5 -> data_out=0xA5 in the next cycle without a read.
